// File: rtl/lfo_gen.sv
// Low-frequency oscillator: phase accumulator -> wave lookup -> depth scaling, three registered stages.
// Define LFO_SINE_TABLE_EN for a raised-cosine wave from a quarter-wave table; default is a triangle.
module lfo_gen #(
  parameter int PHASE_W = 24,
  parameter int WAVE_W  = 10
) (
  input  logic        ADCLRCK,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] rate,
  input  logic [8:0]  depth,
  input  logic        phase_sync,
  output logic [31:0] sin,
  output logic        phase_wrap
);

  // Sum is wide enough for both operands so a carry out of the phase is never lost.
  localparam int SUM_W = ((PHASE_W > 16) ? PHASE_W : 16) + 1;

  logic [PHASE_W-1:0] phase;
  logic [SUM_W-1:0]   sum;
  logic               wrap_next;
  logic               load_depth;
  logic [8:0]         depth_sat;
  logic [8:0]         depth_q;
  logic [WAVE_W-1:0]  p;
  logic [8:0]         wave;
  logic [8:0]         wave_next;
  logic [16:0]        product;

  assign sum        = SUM_W'(phase) + SUM_W'(rate);
  assign wrap_next  = enable & ~phase_sync & (sum[SUM_W-1:PHASE_W] != '0);
  assign depth_sat  = (depth > 9'd256) ? 9'd256 : depth;
  assign load_depth = ~enable | phase_sync | wrap_next;
  assign p          = phase[PHASE_W-1 -: WAVE_W];

`ifdef LFO_SINE_TABLE_EN
  // Evaluated only at elaboration; cosine by Taylor series so no math library is needed.
  function automatic int sine_point(input int i);
    real th;
    real term;
    real c;
    th   = 2.0 * 3.14159265358979 * i / 1024.0;
    c    = 1.0;
    term = 1.0;
    for (int k = 1; k < 14; k++) begin
      term = -term * th * th / ((2.0 * k - 1.0) * (2.0 * k));
      c    = c + term;
    end
    return $rtoi(255.5 * (1.0 - c) + 0.5);
  endfunction

  logic [8:0] qtab [256];
  for (genvar gi = 0; gi < 256; gi++) begin : g_qtab
    assign qtab[gi] = 9'(sine_point(gi));
  end

  logic [9:0] m;
  logic [7:0] idx;

  // Fold into 0..512 by mirror symmetry, then use f(512-m) = 511 - f(m) for the upper half.
  always_comb begin
    m         = p[9] ? 10'(11'd1024 - {1'b0, p}) : p;
    idx       = 8'(~m[7:0] + 8'd1);
    wave_next = 9'd0;
    if (m[9:8] == 2'd0) begin
      wave_next = qtab[m[7:0]];
    end else if (m == 10'd256) begin
      wave_next = 9'd256;
    end else begin
      wave_next = 9'd511 - qtab[idx];
    end
  end
`else
  // Falling half of the triangle: 1023 - p equals the inverted low bits.
  always_comb begin
    wave_next = p[9] ? ~p[8:0] : p[8:0];
  end
`endif

  assign product = 17'(wave) * 17'(depth_q);

  always_ff @(posedge ADCLRCK or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      phase_wrap <= 1'b0;
      depth_q    <= '0;
    end else begin
      phase_wrap <= wrap_next;
      if (phase_sync) begin
        phase <= '0;
      end else if (enable) begin
        phase <= sum[PHASE_W-1:0];
      end
      if (load_depth) begin
        depth_q <= depth_sat;
      end
    end
  end

  // Wave and scaling stages run every edge so frozen phase still settles the output.
  always_ff @(posedge ADCLRCK or posedge rst) begin
    if (rst) begin
      wave <= '0;
      sin  <= '0;
    end else begin
      wave <= wave_next;
      sin  <= 32'(product >> 8);
    end
  end

endmodule

// File: tb/tb_lfo_gen.sv
// Randomized and directed checks of lfo_gen (default triangle build) against a latency-based reference model.
module tb_lfo_gen;

  logic        ADCLRCK = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rate = '0;
  logic [8:0]  depth = '0;
  logic        phase_sync = 1'b0;
  logic [31:0] sin;
  logic        phase_wrap;

  int vectors = 0;
  int miscompares = 0;

  localparam longint MODULUS = 64'd1 << 24;

  // Model: phase after the last edge, phase after the edge before, depth_q after the last edge.
  longint      m_ph1;
  longint      m_ph2;
  int          m_dq1;
  logic [31:0] exp_sin;
  logic        exp_wrap;

  lfo_gen #(.PHASE_W(24), .WAVE_W(10)) dut (
    .ADCLRCK   (ADCLRCK),
    .rst       (rst),
    .enable    (enable),
    .rate      (rate),
    .depth     (depth),
    .phase_sync(phase_sync),
    .sin       (sin),
    .phase_wrap(phase_wrap)
  );

  always #5 ADCLRCK = ~ADCLRCK;

  function automatic int tri_f(input longint ph);
    int pv;
    pv = int'(ph >> 14);
    return (pv < 512) ? pv : 1023 - pv;
  endfunction

  // One sample period: drive inputs, take the edge, predict outputs from the phase two edges back.
  task automatic step(input bit e, input bit s, input int r, input int d);
    longint nxt;
    enable     = e;
    phase_sync = s;
    rate       = 16'(r);
    depth      = 9'(d);
    @(posedge ADCLRCK);
    #1;
    nxt      = m_ph1 + r;
    exp_wrap = e && !s && (nxt >= MODULUS);
    exp_sin  = 32'((tri_f(m_ph2) * m_dq1) >> 8);
    m_ph2    = m_ph1;
    if (s) m_ph1 = 0;
    else if (e) m_ph1 = nxt % MODULUS;
    if (!e || s || exp_wrap) m_dq1 = (d > 256) ? 256 : d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    phase_sync = 1'b0;
    rate = '0;
    depth = '0;
    @(posedge ADCLRCK);
    #1;
    rst = 1'b0;
    m_ph1 = 0;
    m_ph2 = 0;
    m_dq1 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (sin !== 32'd0) begin miscompares++; $display("FAIL reset_sin: got %0d expected 0", sin); end
    vectors++;
    if (phase_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %0b expected 0", phase_wrap); end
    // depth_q stays 0 while enabled with no wrap, so the output must stay 0
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 16'h8000, 256);
      vectors++;
      if (sin !== 32'd0 || sin !== exp_sin) begin
        miscompares++; $display("FAIL post_reset_zero: got %0d expected 0", sin);
      end
    end
  endtask

  task automatic test_triangle();
    int peak;
    int peak_tick;
    int wraps;
    logic [31:0] at_zero;
    do_reset();
    step(0, 0, 16'h8000, 256);
    peak = 0; peak_tick = -1; wraps = 0; at_zero = 32'hffff_ffff;
    for (int k = 1; k <= 1100; k++) begin
      step(1, 0, 16'h8000, 256);
      vectors++;
      if (sin !== exp_sin || phase_wrap !== exp_wrap) begin
        miscompares++;
        $display("FAIL triangle_tick%0d: got sin=%0d wrap=%0b expected sin=%0d wrap=%0b", k, sin, phase_wrap, exp_sin, exp_wrap);
      end
      if (int'(sin) > peak) begin peak = int'(sin); peak_tick = k; end
      if (phase_wrap === 1'b1) wraps++;
      if (k == 514) at_zero = sin;
    end
    vectors++;
    if (peak !== 511 || peak_tick !== 258) begin
      miscompares++; $display("FAIL triangle_peak: got %0d at tick %0d expected 511 at tick 258", peak, peak_tick);
    end
    vectors++;
    if (at_zero !== 32'd0) begin miscompares++; $display("FAIL triangle_return: got %0d expected 0", at_zero); end
    vectors++;
    if (wraps !== 2) begin miscompares++; $display("FAIL triangle_wraps: got %0d expected 2", wraps); end
  endtask

  task automatic test_depth_change();
    int peak;
    bit seen;
    do_reset();
    step(0, 0, 16'h8000, 256);
    for (int k = 0; k < 100; k++) step(1, 0, 16'h8000, 256);
    peak = 0; seen = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      step(1, 0, 16'h8000, 128);
      vectors++;
      if (sin !== exp_sin || phase_wrap !== exp_wrap) begin
        miscompares++; $display("FAIL depth_pre_wrap: got sin=%0d wrap=%0b expected sin=%0d wrap=%0b", sin, phase_wrap, exp_sin, exp_wrap);
      end
      if (int'(sin) > peak) peak = int'(sin);
      if (phase_wrap === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || peak !== 511) begin
      miscompares++; $display("FAIL depth_old_peak: got %0d wrap_seen=%0b expected 511 wrap_seen=1", peak, seen);
    end
    peak = 0;
    for (int k = 0; k < 514; k++) begin
      step(1, 0, 16'h8000, 128);
      if (int'(sin) > peak) peak = int'(sin);
    end
    vectors++;
    if (peak !== 255) begin miscompares++; $display("FAIL depth_new_peak: got %0d expected 255", peak); end
  endtask

  task automatic test_sync();
    do_reset();
    step(0, 0, 16'h8000, 256);
    for (int k = 0; k < 511; k++) step(1, 0, 16'h8000, 256);
    step(1, 1, 16'h8000, 256);
    vectors++;
    if (phase_wrap !== 1'b0 || exp_wrap !== 1'b0) begin
      miscompares++; $display("FAIL sync_no_wrap: got %0b expected 0", phase_wrap);
    end
    step(1, 0, 16'h8000, 256);
    vectors++;
    if (sin !== exp_sin) begin miscompares++; $display("FAIL sync_n1: got %0d expected %0d", sin, exp_sin); end
    step(1, 0, 16'h8000, 256);
    vectors++;
    if (sin !== 32'd0) begin miscompares++; $display("FAIL sync_n2_zero: got %0d expected 0", sin); end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    int r;
    do_reset();
    step(0, 0, 0, 200);
    for (int k = 0; k < 37; k++) begin
      r = $urandom_range(1, 65535);
      step(1, 0, r, 200);
    end
    for (int k = 0; k < 1000; k++) begin
      step(1, 0, 0, 200);
      if (k == 1) held = sin;
      if (k >= 1) begin
        vectors++;
        if (sin !== held || sin !== exp_sin || phase_wrap !== 1'b0) begin
          miscompares++; $display("FAIL hold_rate0: got sin=%0d wrap=%0b expected sin=%0d wrap=0", sin, phase_wrap, exp_sin);
        end
      end
    end
    for (int k = 0; k < 60; k++) begin
      step(0, 0, $urandom_range(0, 65535), 200);
      if (k == 1) held = sin;
      if (k >= 1) begin
        vectors++;
        if (sin !== held || sin !== exp_sin || phase_wrap !== 1'b0) begin
          miscompares++; $display("FAIL hold_disabled: got sin=%0d wrap=%0b expected sin=%0d wrap=0", sin, phase_wrap, exp_sin);
        end
      end
    end
  endtask

  task automatic test_random();
    bit e;
    bit s;
    int r;
    int d;
    do_reset();
    d = $urandom_range(0, 511);
    for (int k = 0; k < 3000; k++) begin
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535);
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 511);
      step(e, s, r, d);
      vectors++;
      if (sin !== exp_sin || phase_wrap !== exp_wrap) begin
        miscompares++;
        $display("FAIL random_tick%0d: got sin=%0d wrap=%0b expected sin=%0d wrap=%0b", k, sin, phase_wrap, exp_sin, exp_wrap);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    step(0, 0, 16'h8000, 256);
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      step(1, 0, 16'h8000, 256);
      if (sin === 32'd300) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL midreset_reach300: got not reached expected sin=300"); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (sin !== 32'd0 || phase_wrap !== 1'b0) begin
      miscompares++; $display("FAIL midreset_async: got sin=%0d wrap=%0b expected 0 0", sin, phase_wrap);
    end
    #2;
    rst = 1'b0;
    m_ph1 = 0; m_ph2 = 0; m_dq1 = 0;
    for (int k = 0; k < 30; k++) begin
      step(1, 0, 16'h8000, 256);
      vectors++;
      if (sin !== 32'd0 || sin !== exp_sin) begin
        miscompares++; $display("FAIL midreset_release: got %0d expected 0", sin);
      end
    end
  endtask

  initial begin
    m_ph1 = 0; m_ph2 = 0; m_dq1 = 0;
    test_reset();
    test_triangle();
    test_depth_change();
    test_sync();
    test_hold();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfo_gen.md
LFO_GEN -- requirements
Module: lfo_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, phase-accumulator width; legal range 12..32.
REQ-002 SHALL have parameter WAVE_W, default 10, phase bits used for wave lookup; fixed at 10.
REQ-003 SHALL have port ADCLRCK  input  1  sample-rate clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset: reset ADCLRCK, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  1 = phase advances, 0 = phase frozen.
REQ-006 SHALL have port rate  input  16  unsigned phase increment per sample.
REQ-007 SHALL have port depth  input  9  unsigned modulation depth, 0..256; values above 256 treated as 256.
REQ-008 SHALL have port phase_sync  input  1  restart phase at 0.
REQ-009 SHALL have port sin  output  32  unsigned modulation value 0..511, bits 31:9 always 0, feeds the vibrato delay-time input.
REQ-010 SHALL have port phase_wrap  output  1  one-cycle pulse on accumulator wrap.

Function
REQ-011 Stage 1: at each posedge, phase SHALL become 0 if phase_sync=1, else phase+rate modulo 2^PHASE_W if enable=1, else hold.
REQ-012 phase_wrap SHALL be registered with stage 1 and be 1 only for the edge where enable=1, phase_sync=0 and phase+rate >= 2^PHASE_W.
REQ-013 phase_sync SHALL take priority over enable and wrap; a sync SHALL never produce a phase_wrap pulse.
REQ-014 Stage 2: p = phase[PHASE_W-1 -: 10]; wave SHALL be registered as f(p), a value in 0..511.
REQ-015 Default wave SHALL be a triangle: f(p) = p for p < 512, else 1023 - p.
REQ-016 depth_q SHALL load min(depth,256) on any edge with enable=0, phase_sync=1, or phase_wrap being set; otherwise it SHALL hold, so depth changes take effect only on cycle boundaries.
REQ-017 Stage 3: sin SHALL be registered as (wave * depth_q) >> 8, truncated, zero-extended to 32 bits; max 511.
REQ-018 Latency: a phase update at edge n SHALL appear on sin at edge n+2; the pipeline SHALL run every edge regardless of enable.
REQ-019 With enable=0 held, sin SHALL be constant from the second edge onward.
REQ-020 rate=0 with enable=1 SHALL hold phase and never pulse phase_wrap.

Reset
REQ-021 rst=1 SHALL asynchronously clear phase, wave, depth_q, sin and phase_wrap to 0.
REQ-022 After rst deasserts, sin SHALL stay 0 until depth_q is loaded per REQ-016.
REQ-023 rst asserted mid-cycle SHALL discard all in-flight pipeline values; no partial output SHALL appear after release.

Configuration
REQ-024 Macro LFO_SINE_TABLE_EN: when defined, f(p) SHALL equal round(255.5 * (1 - cos(2*pi*p/1024))), range 0..511, built from a 256-entry quarter-wave table with symmetry folding.
REQ-025 Without LFO_SINE_TABLE_EN, f(p) SHALL be the triangle of REQ-015, and no table logic SHALL be synthesized.
REQ-026 Latency, interface and depth behaviour SHALL be identical in both configurations.

Verification
REQ-027 Reset mid-run: rst=1 while sin=300 -> sin=0 and phase_wrap=0 immediately, before the next clock edge.
REQ-028 Triangle case (no macro): PHASE_W=24, rate=0x8000, depth=256, one edge with enable=0, then enable=1 -> sin steps 0, 2, 4, ..., reaches 511 at 256 ticks, returns to 0, phase_wrap pulses every 512 ticks.
REQ-029 Depth change: depth changed 256->128 mid-cycle -> peak stays 511 for the current cycle, and is 255 after the next phase_wrap.
REQ-030 Sync: phase_sync=1 at edge n with phase near wrap -> phase=0 at edge n, sin=0 at edge n+2, no phase_wrap pulse.
REQ-031 Sine table (LFO_SINE_TABLE_EN): p=0 -> 0; p=256 -> 256; p=512 -> 511; p=768 -> 256; with depth=256.
REQ-032 Hold cases: rate=0, enable=1 -> sin constant for 1000 ticks with no phase_wrap; enable=0 -> sin frozen.
